cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
// - Transmit side of the common data bus. Functional units (adder RS, load unit) hand
//   results {robNum, data} to this block instead of driving a CDB directly.
// - Queues them per source and broadcasts at most one result per cycle in round-robin order.
// - The registered broadcast (iscast_out/robNum_out/data_out) feeds every CDB receiver:
//   RS operand snoop and ROB result write.
// PARAMETERS
// NUM_SRC    2   number of producing units; src 0 = adder, src 1 = load unit
// DEPTH      2   entries per source queue (power of 2, >=2)
// DATA_W     32  result data width
// ROB_IDX_W  3   ROB index width
// PORTS
// clock       in   1                  system clock; all state updates on posedge
// reset       in   1                  synchronous, active-high; driven by ROB resetAll (flush)
// src_valid   in   NUM_SRC            src i presents a result this cycle
// src_ready   out  NUM_SRC            src i queue can accept this cycle
// src_robNum  in   NUM_SRC*ROB_IDX_W  src i ROB tag, slice [i*ROB_IDX_W +: ROB_IDX_W]
// src_data    in   NUM_SRC*DATA_W     src i result, slice [i*DATA_W +: DATA_W]
// iscast_out  out  1                  broadcast valid, exactly one cycle per result
// robNum_out  out  ROB_IDX_W          broadcast ROB tag
// data_out    out  DATA_W             broadcast data
// pending     out  NUM_SRC            src i queue non-empty (debug/stall visibility)
// BEHAVIOUR
// - Accept: entry pushed at posedge when src_valid[i] && src_ready[i].
//   src_ready[i] = !reset && count[i] < DEPTH (combinational; no same-cycle pop credit).
//   src_valid with ready low: nothing captured; the source holds its data and retries.
// - Arbitration, every cycle, over queues non-empty at the start of the cycle:
//   - rr_ptr names the highest-priority source; search rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//   - First non-empty queue wins; its head is popped at posedge.
//   - rr_ptr <= (winner+1) mod NUM_SRC.
//   - No winner: rr_ptr holds.
// - Output register:
//   - Grant: iscast_out <= 1; robNum_out/data_out <= winner head.
//   - No grant: iscast_out <= 0; robNum_out/data_out hold their last values.
// - Latency: an entry accepted at edge N is visible no earlier than after edge N+1
//   (one full cycle). There is no bypass from src to output.
// - Order: FIFO per source. No ordering is guaranteed across sources.
// - Simultaneous push+pop on one queue: both occur; count unchanged.
//   Pointers wrap mod DEPTH.
// - Full: ready low until a pop; a pop at edge N re-raises ready for the cycle after N.
// - Empty: all queues empty -> iscast_out 0 next cycle.
// - Reset (any cycle, including mid-broadcast), values after the reset edge:
//   - Queues: all counts = 0, rd/wr pointers = 0; in-flight entries are dropped.
//   - rr_ptr = 0.
//   - iscast_out = 0, robNum_out = 0, data_out = 0.
//   - pending = 0; src_ready = 0 while reset is high.
//   - Pushes presented during a reset cycle are discarded.
// - Widths: count per queue is $clog2(DEPTH)+1 bits. No arithmetic on data (pass-through).
// - Uniqueness: one result per ROB tag is expected per flush epoch. The block does not check.
// STRUCTURE
// - Shared package/header cpu_defs:
//   - DATA_W, ROB_IDX_W constants.
//   - cdb_entry_t = {robNum[ROB_IDX_W], data[DATA_W]}.
// - Sub-module cdb_src_fifo (one per source, generate loop):
//   - DEPTH-entry cdb_entry_t circular buffer.
//   - Ports: clock, reset, push, din, pop, dout, full, empty.
// - Top-level keeps only rr_ptr, the arbiter priority search, and the output register.
// TESTING
// 1. Reset: hold reset 2 cycles with src_valid=2'b11 ->
//    iscast_out=0, robNum_out=0, data_out=0, src_ready=0, pending=0; nothing broadcast after.
// 2. Single result: src0 pushes {rob 3, 0x0000_0005} at edge N, no other traffic ->
//    iscast_out=1, robNum_out=3, data_out=5 after edge N+1; iscast_out=0 after edge N+2.
// 3. Round-robin: both sources push one entry on the same edge
//    (src0 {1,0xA}, src1 {2,0xB}), rr_ptr=0 ->
//    broadcasts rob1/0xA then rob2/0xB in consecutive cycles; a new pair then goes src0 first.
// 4. Full/back-pressure: src1 pushes rob4,5,6 back-to-back while src0 is kept busy ->
//    src_ready[1] low once 2 entries are held; rob6 captured only after a src1 pop;
//    broadcast order 4,5,6.
// 5. Flush mid-operation: queues hold 3 entries, assert reset 1 cycle ->
//    iscast_out=0 on the next cycle; no stale tag is ever broadcast;
//    a fresh push after reset broadcasts normally.
// 6. Saturation: both sources push every cycle for 20 cycles ->
//    iscast_out high every cycle once primed; grants alternate 0,1,0,1;
//    no entry lost or duplicated (scoreboard on robNum/data).

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU constants and the result record carried on the common data bus.
// Also holds the round-robin successor helper used by the CDB arbiter.
package cpu_defs;

   localparam int DATA_W    = 32;
   localparam int ROB_IDX_W = 3;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] robNum;
      logic [DATA_W-1:0]    data;
   } cdb_entry_t;

   // Next source after cur, wrapping at n (n need not be a power of two).
   function automatic int rr_next(input int cur, input int n);
      return (cur >= n - 1) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source circular buffer of CDB results awaiting broadcast.
// Push is ignored when full and pop is ignored when empty.
module cdb_src_fifo
   import cpu_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  cdb_entry_t din,
   input  logic       pop,
   output cdb_entry_t dout,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   cdb_entry_t       mem_q [DEPTH];
   cdb_entry_t       mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus transmit side: per-source result queues drained one per cycle
// in round-robin order into a registered broadcast.
module cdb_arbiter
   import cpu_defs::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_SRC-1:0]           src_valid,
   output logic [NUM_SRC-1:0]           src_ready,
   input  logic [NUM_SRC*ROB_IDX_W-1:0] src_robNum,
   input  logic [NUM_SRC*DATA_W-1:0]    src_data,
   output logic                         iscast_out,
   output logic [ROB_IDX_W-1:0]         robNum_out,
   output logic [DATA_W-1:0]            data_out,
   output logic [NUM_SRC-1:0]           pending
);

   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   cdb_entry_t           din  [NUM_SRC];
   cdb_entry_t           head [NUM_SRC];
   logic [NUM_SRC-1:0]   push;
   logic [NUM_SRC-1:0]   pop;
   logic [NUM_SRC-1:0]   full;
   logic [NUM_SRC-1:0]   empty;

   logic                 grant;
   logic [SRC_W-1:0]     winner;
   int                   idx;

   logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic                 iscast_q, iscast_d;
   logic [ROB_IDX_W-1:0] rob_q, rob_d;
   logic [DATA_W-1:0]    data_q, data_d;

   // Ready is forced low during reset so a flush cycle cannot capture a push.
   assign src_ready = ~full & {NUM_SRC{~reset}};
   assign push      = src_valid & src_ready;
   assign pending   = ~empty;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      assign din[i].robNum = src_robNum[i*ROB_IDX_W +: ROB_IDX_W];
      assign din[i].data   = src_data[i*DATA_W +: DATA_W];

      cdb_src_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock (clock),
         .reset (reset),
         .push  (push[i]),
         .din   (din[i]),
         .pop   (pop[i]),
         .dout  (head[i]),
         .full  (full[i]),
         .empty (empty[i])
      );
   end

   // Search from rr_ptr upward; the first non-empty queue wins and is popped.
   always_comb begin
      grant  = 1'b0;
      winner = '0;
      idx    = 0;
      pop    = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_SRC;
         if (!grant && !empty[SRC_W'(idx)]) begin
            grant  = 1'b1;
            winner = SRC_W'(idx);
         end
      end
      if (grant) begin
         pop[winner] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      iscast_d = grant;
      rob_d    = rob_q;
      data_d   = data_q;
      if (grant) begin
         rr_ptr_d = SRC_W'(rr_next(int'(winner), NUM_SRC));
         rob_d    = head[winner].robNum;
         data_d   = head[winner].data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q <= '0;
         iscast_q <= 1'b0;
         rob_q    <= '0;
         data_q   <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         iscast_q <= iscast_d;
         rob_q    <= rob_d;
         data_q   <= data_d;
      end
   end

   assign iscast_out = iscast_q;
   assign robNum_out = rob_q;
   assign data_out   = data_q;

endmodule
